ram_responder: RTL and testbench



---
 rtl/ram_responder.sv | 79 +++++++
 tb/tb_ram_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: word-addressed single-port RAM answering ram_if requests with a programmable BUSY latency.
package ram_responder_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LAT = 2
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output ramstate_t ramstate,
  output word_t     ramload
);
  typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   cap_ren_q, cap_wen_q;
  logic [ADDR_BITS-1:0]   cap_idx_q;
  word_t                  ramload_q;
  word_t                  mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]   idx;
  logic                   oor, any, bad, valid, changed, go, unused_addr;
  assign idx         = ramaddr[ADDR_BITS+1:2];
  assign oor         = |ramaddr[31:ADDR_BITS+2];
  assign any         = ramREN | ramWEN;
  assign bad         = (ramREN & ramWEN) | (any & oor);
  assign valid       = (ramREN ^ ramWEN) & ~oor;
  assign changed     = (ramREN != cap_ren_q) | (ramWEN != cap_wen_q) | (idx != cap_idx_q);
  assign unused_addr = ^ramaddr[1:0];
  // The access uses the live request: in WAIT it only fires when it matches the captured one.
  assign go          = valid & ((state_q == IDLE && LAT == 0) | (state_q == WAIT && !changed && cnt_q == '0));
  assign ramstate    = ramstate_t'(state_q);
  assign ramload     = ramload_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ramload_q <= '0;
    end else begin
      if (go && ramREN) ramload_q <= mem[idx];
      case (state_q)
        IDLE: if (bad) state_q <= ERR;
              else if (valid) begin
                if (LAT == 0) state_q <= ACC;
                else begin
                  state_q   <= WAIT;
                  cnt_q     <= LAT_M1;
                  cap_ren_q <= ramREN;
                  cap_wen_q <= ramWEN;
                  cap_idx_q <= idx;
                end
              end
        WAIT: if (!any) state_q <= IDLE;
              else if (bad) state_q <= ERR;
              else if (changed) begin
                cnt_q     <= LAT_M1;
                cap_ren_q <= ramREN;
                cap_wen_q <= ramWEN;
                cap_idx_q <= idx;
              end else if (cnt_q == '0) state_q <= ACC;
              else cnt_q <= cnt_q - 1'b1;
        ACC:  state_q <= IDLE;
        ERR:  if (!any) state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST && go && ramWEN) mem[idx] <= ramstore;
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: vector table plus hand sequences, with a read-data scoreboard queue, for LAT=2 and LAT=0 instances.
module tb_ram_responder;
  import ram_responder_pkg::*;
  logic clk = 1'b0, rst;
  logic ren, wen, ren0, wen0;
  word_t addr, store, addr0, store0, ld2, ld0;
  ramstate_t st2, st0;
  int compared = 0, mismatched = 0;
  word_t exp_q[$];
  word_t last_load;
  typedef struct {logic r; logic w; word_t a; word_t d; word_t exp;} vec_t;
  vec_t tbl[10];

  ram_responder #(.ADDR_BITS(10), .LAT(2)) u2 (.CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(store), .ramstate(st2), .ramload(ld2));
  ram_responder #(.ADDR_BITS(10), .LAT(0)) u0 (.CLK(clk), .RST(rst), .ramREN(ren0), .ramWEN(wen0),
    .ramaddr(addr0), .ramstore(store0), .ramstate(st0), .ramload(ld0));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t v, input string nm);
    int n = 0;
    ren = v.r; wen = v.w; addr = v.a; store = v.d;
    if (v.r) exp_q.push_back(v.exp);
    do begin
      @(negedge clk);
      n++;
    end while (st2 != ACCESS && n < 8);
    chk({nm, "_lat"}, 32'(n), 32'd3);
    if (v.r) begin
      chk({nm, "_load"}, ld2, exp_q.pop_front());
      last_load = v.exp;
    end
    ren = 0; wen = 0;
    @(negedge clk);
    chk({nm, "_free"}, 32'(st2), 32'(FREE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'h40,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'h42,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 32'h80,  32'hCAFEF00D, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 32'h44,  32'h0,        32'h0};
    tbl[5] = '{1'b0, 1'b1, 32'h48,  32'h11111111, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h80,  32'h0,        32'hCAFEF00D};
    tbl[7] = '{1'b0, 1'b1, 32'hFFC, 32'h600DF00D, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 32'hFFC, 32'h0,        32'h600DF00D};
    tbl[9] = '{1'b1, 1'b0, 32'h44,  32'h0,        32'h0};
    rst = 1;
    ren = 1'($urandom); wen = 1'($urandom); addr = $urandom; store = $urandom;
    ren0 = 1'($urandom); wen0 = 1'($urandom); addr0 = $urandom; store0 = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; ren = 0; wen = 0; addr = 0; store = 0; ren0 = 0; wen0 = 0; addr0 = 0; store0 = 0;
    chk("rst_state", 32'(st2), 32'(FREE));
    chk("rst_load", ld2, 32'h0);
    chk("rst_state0", 32'(st0), 32'(FREE));
    last_load = 0;
    for (int i = 0; i < 10; i++) txn(tbl[i], $sformatf("vec%0d", i));
    // abort after one BUSY cycle: the write must not land
    wen = 1; addr = 32'h44; store = 32'h12345678;
    @(negedge clk); chk("abort_busy", 32'(st2), 32'(BUSY));
    wen = 0;
    @(negedge clk); chk("abort_free", 32'(st2), 32'(FREE));
    txn('{1'b1, 1'b0, 32'h44, 32'h0, 32'h0}, "abort_rd");
    // restart: address moves after one BUSY cycle
    ren = 1; addr = 32'h40;
    @(negedge clk); chk("rs_busy0", 32'(st2), 32'(BUSY));
    addr = 32'h80; exp_q.push_back(32'hCAFEF00D);
    @(negedge clk); chk("rs_busy1", 32'(st2), 32'(BUSY));
    @(negedge clk); chk("rs_busy2", 32'(st2), 32'(BUSY));
    @(negedge clk); chk("rs_acc", 32'(st2), 32'(ACCESS));
    chk("rs_load", ld2, exp_q.pop_front());
    last_load = 32'hCAFEF00D;
    ren = 0;
    @(negedge clk); chk("rs_free", 32'(st2), 32'(FREE));
    // errors
    ren = 1; wen = 1; addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk($sformatf("err_both%0d", i), 32'(st2), 32'(ERROR));
    end
    ren = 0; wen = 0;
    @(negedge clk); chk("err_free", 32'(st2), 32'(FREE));
    ren = 1; addr = 32'h1000;
    @(negedge clk); chk("oor_state", 32'(st2), 32'(ERROR));
    chk("oor_load", ld2, last_load);
    ren = 0;
    @(negedge clk); chk("oor_free", 32'(st2), 32'(FREE));
    // reset in the second BUSY cycle discards the write
    wen = 1; addr = 32'h48; store = 32'hA5A5A5A5;
    @(negedge clk); chk("rm_busy0", 32'(st2), 32'(BUSY));
    @(negedge clk); chk("rm_busy1", 32'(st2), 32'(BUSY));
    rst = 1;
    @(negedge clk);
    rst = 0; wen = 0;
    chk("rm_free", 32'(st2), 32'(FREE));
    chk("rm_load", ld2, 32'h0);
    txn('{1'b1, 1'b0, 32'h48, 32'h0, 32'h11111111}, "rm_rd");
    // LAT=0 instance
    wen0 = 1; addr0 = 32'h40; store0 = 32'h55AA55AA;
    @(negedge clk); chk("l0_wacc", 32'(st0), 32'(ACCESS));
    wen0 = 0;
    @(negedge clk); chk("l0_wfree", 32'(st0), 32'(FREE));
    ren0 = 1; exp_q.push_back(32'h55AA55AA);
    @(negedge clk); chk("l0_racc", 32'(st0), 32'(ACCESS));
    chk("l0_load", ld0, exp_q.pop_front());
    ren0 = 0;
    @(negedge clk); chk("l0_rfree", 32'(st0), 32'(FREE));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
